// File: rtl/streamed_data_broadcast_fifo_if.sv
// Stream bundle for the broadcast FIFO: producer side (s_*), consumer side (m_*) and occupancy.
// master = producers/consumers around the block, slave = the FIFO itself.
//
// Ports (all packed per stream, index [stream]):
//   s_data     DATA_W        producer data
//   s_valid    1             producer valid
//   s_ready    1             FIFO can accept
//   m_data     DATA_W        head entry, shared by all consumers of a stream
//   m_valid    NUM_CONSUMERS per-consumer valid
//   m_ready    NUM_CONSUMERS per-consumer ready
//   occupancy  CNT_W         entries held
interface streamed_data_broadcast_fifo_if #(
    parameter int NUM_STREAMS   = 32,
    parameter int DATA_W        = 1024,
    parameter int NUM_CONSUMERS = 2,
    parameter int CNT_W         = 3
);
    logic [NUM_STREAMS-1:0][DATA_W-1:0]        s_data;
    logic [NUM_STREAMS-1:0]                    s_valid;
    logic [NUM_STREAMS-1:0]                    s_ready;
    logic [NUM_STREAMS-1:0][DATA_W-1:0]        m_data;
    logic [NUM_STREAMS-1:0][NUM_CONSUMERS-1:0] m_valid;
    logic [NUM_STREAMS-1:0][NUM_CONSUMERS-1:0] m_ready;
    logic [NUM_STREAMS-1:0][CNT_W-1:0]         occupancy;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  occupancy
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_valid,
        input  m_ready,
        output occupancy
    );
endinterface

// File: rtl/streamed_data_broadcast_fifo.sv
// Per-stream FIFO whose head entry is broadcast to several consumers; an entry
// retires once every enabled consumer has taken it.
//
// Ports:
//   clk              rising-edge clock
//   resetn           asynchronous active-low reset
//   flush            synchronous clear of all FIFOs and served state
//   consumer_enable  mask of consumers that must take each entry
//   bus              stream bundle (slave side): s_data/s_valid/s_ready,
//                    m_data/m_valid/m_ready, occupancy
module streamed_data_broadcast_fifo #(
    parameter int NUMBER_OF_READ_STREAMS       = 32,
    parameter int ACTIVATION_BANK_BIT_WIDTH    = 32,
    parameter int ACTIVATION_BUFFER_BANK_COUNT = 32,
    parameter int NUMBER_OF_CONSUMERS          = 2,
    parameter int FIFO_DEPTH                   = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           flush,
    input  logic [NUMBER_OF_CONSUMERS-1:0] consumer_enable,
    streamed_data_broadcast_fifo_if.slave  bus
);

    localparam int NS     = NUMBER_OF_READ_STREAMS;
    localparam int NC     = NUMBER_OF_CONSUMERS;
    localparam int DATA_W = ACTIVATION_BANK_BIT_WIDTH * ACTIVATION_BUFFER_BANK_COUNT;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Held low through reset and set by the first edge after release, so
    // producers never see ready while the block is still being reset.
    logic alive_q;
    logic alive_d;

    assign alive_d = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= alive_d;
        end
    end

    logic [NS-1:0]             s_ready_w;
    logic [NS-1:0][DATA_W-1:0] m_data_w;
    logic [NS-1:0][NC-1:0]     m_valid_w;
    logic [NS-1:0][CNT_W-1:0]  occ_w;

    for (genvar s = 0; s < NS; s++) begin : g_stream
        logic [CNT_W-1:0]  count_q;
        logic [CNT_W-1:0]  count_d;
        logic [PTR_W-1:0]  wr_ptr_q;
        logic [PTR_W-1:0]  wr_ptr_d;
        logic [PTR_W-1:0]  rd_ptr_q;
        logic [PTR_W-1:0]  rd_ptr_d;
        logic [NC-1:0]     served_q;
        logic [NC-1:0]     served_d;
        logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

        logic              empty;
        logic              ready;
        logic              push;
        logic              pop;
        logic [NC-1:0]     valid;
        logic [NC-1:0]     hs;
        logic [NC-1:0]     done;

        always_comb begin
            empty = (count_q == '0);
            // Ready looks only at the registered count: a full FIFO does
            // not accept in the cycle it pops.
            ready = alive_q && !flush && (count_q < CNT_FULL);
            push  = bus.s_valid[s] && ready;
            valid = {NC{!empty}} & consumer_enable & ~served_q;
            hs    = valid & bus.m_ready[s];
            // A consumer is finished with the head if it is disabled,
            // already served, or handshaking right now.
            done  = ~consumer_enable | served_q | hs;
            pop   = (|consumer_enable) && !empty && (&done);

            count_d  = count_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            served_d = served_q;

            if (flush) begin
                count_d  = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                served_d = '0;
            end else begin
                if (pop) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                    served_d = '0;
                end else begin
                    // Disabled consumers never handshake, so their
                    // served bits simply hold until the pop.
                    served_d = served_q | hs;
                end
                if (push) begin
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end
                count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                count_q  <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                served_q <= '0;
            end else begin
                count_q  <= count_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                served_q <= served_d;
            end
        end

        // Storage carries no reset; contents are only observed when the
        // count says they are valid.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.s_data[s];
            end
        end

        assign s_ready_w[s] = ready;
        assign m_valid_w[s] = valid;
        assign m_data_w[s]  = mem_q[rd_ptr_q];
        assign occ_w[s]     = count_q;
    end

    assign bus.s_ready   = s_ready_w;
    assign bus.m_valid   = m_valid_w;
    assign bus.m_data    = m_data_w;
    assign bus.occupancy = occ_w;

endmodule

// File: tb/tb_streamed_data_broadcast_fifo.sv
// Randomized plus directed bench for the broadcast FIFO, checked against a
// queue-per-stream model of the retire-when-all-enabled-consumers-served rule.
module tb_streamed_data_broadcast_fifo;

    localparam int NS = 4;
    localparam int BW = 8;
    localparam int BC = 4;
    localparam int DW = BW * BC;
    localparam int NC = 2;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic [NC-1:0] en;

    streamed_data_broadcast_fifo_if #(
        .NUM_STREAMS(NS), .DATA_W(DW), .NUM_CONSUMERS(NC), .CNT_W(CW)
    ) bus ();

    streamed_data_broadcast_fifo #(
        .NUMBER_OF_READ_STREAMS(NS),
        .ACTIVATION_BANK_BIT_WIDTH(BW),
        .ACTIVATION_BUFFER_BANK_COUNT(BC),
        .NUMBER_OF_CONSUMERS(NC),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .flush(flush),
        .consumer_enable(en),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q [NS][$];
    logic [NC-1:0] srv [NS];
    bit            acc [NS];
    int            pops [NS];
    logic [DW-1:0] obs0 [$];
    int            vecs = 0;
    int            errs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            q[s].delete();
            srv[s] = '0;
            acc[s] = 1'b0;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Compare outputs against the model, advance the model, cross one edge.
    task automatic cyc();
        #1;
        for (int s = 0; s < NS; s++) begin
            int            sz;
            logic [NC-1:0] mv;
            logic [NC-1:0] hs;
            logic          pop;
            logic          push;
            sz = q[s].size();
            mv = (sz != 0) ? (en & ~srv[s]) : '0;
            chk($sformatf("s%0d.s_ready", s), 64'(bus.s_ready[s]), 64'(!flush && sz < D));
            chk($sformatf("s%0d.m_valid", s), 64'(bus.m_valid[s]), 64'(mv));
            chk($sformatf("s%0d.occupancy", s), 64'(bus.occupancy[s]), 64'(sz));
            if (sz != 0)
                chk($sformatf("s%0d.m_data", s), 64'(bus.m_data[s]), 64'(q[s][0]));
            hs   = mv & bus.m_ready[s];
            pop  = !flush && (en != '0) && (sz != 0) && ((srv[s] | hs | ~en) == '1);
            push = !flush && bus.s_valid[s] && (sz < D);
            acc[s] = push;
            if (pop) begin
                pops[s]++;
                if (s == 0) obs0.push_back(bus.m_data[0]);
            end
            if (flush) begin
                q[s].delete();
                srv[s] = '0;
            end else begin
                if (pop) begin
                    void'(q[s].pop_front());
                    srv[s] = '0;
                end else begin
                    srv[s] = srv[s] | hs;
                end
                if (push) q[s].push_back(bus.s_data[s]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Random producer/consumer drive; a pending unaccepted word is held.
    task automatic drive_rand(input int s, input int vpct, input int rpct);
        if (!(bus.s_valid[s] && !acc[s])) begin
            bus.s_valid[s] = ($urandom_range(0, 99) < vpct);
            bus.s_data[s]  = DW'($urandom);
        end
        for (int c = 0; c < NC; c++)
            bus.m_ready[s][c] = ($urandom_range(0, 99) < rpct);
    endtask

    initial begin
        int k;
        logic [DW-1:0] seq0;
        resetn      = 1'b0;
        flush       = 1'b0;
        en          = '1;
        bus.s_data  = '0;
        bus.s_valid = '0;
        bus.m_ready = '0;
        model_reset();
        for (int s = 0; s < NS; s++) pops[s] = 0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        settle();
        for (int s = 0; s < NS; s++) begin
            chk("rst.occupancy", 64'(bus.occupancy[s]), 64'(0));
            chk("rst.m_valid", 64'(bus.m_valid[s]), 64'(0));
            chk("rst.s_ready", 64'(bus.s_ready[s]), 64'(0));
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        settle();
        chk("rel.s_ready", 64'(bus.s_ready[0]), 64'(1));

        // basic push / broadcast / pop
        bus.m_ready = '1;
        bus.s_valid[0] = 1'b1;
        bus.s_data[0]  = 'hA1;
        cyc();
        bus.s_valid[0] = 1'b0;
        settle();
        chk("basic.m_valid", 64'(bus.m_valid[0]), 64'h3);
        chk("basic.m_data", 64'(bus.m_data[0]), 64'hA1);
        chk("basic.occ1", 64'(bus.occupancy[0]), 64'd1);
        cyc();
        settle();
        chk("basic.occ0", 64'(bus.occupancy[0]), 64'd0);

        // staggered consumers
        bus.m_ready = '0;
        bus.s_valid[0] = 1'b1;
        bus.s_data[0]  = 'hB0;
        cyc();
        bus.s_data[0]  = 'hB1;
        cyc();
        bus.s_valid[0] = 1'b0;
        bus.m_ready[0] = 2'b01;
        settle();
        chk("stag.both", 64'(bus.m_valid[0]), 64'h3);
        cyc();
        bus.m_ready[0] = 2'b00;
        settle();
        chk("stag.c0_done", 64'(bus.m_valid[0]), 64'h2);
        cyc();
        cyc();
        settle();
        chk("stag.c1_wait", 64'(bus.m_valid[0]), 64'h2);
        chk("stag.occ2", 64'(bus.occupancy[0]), 64'd2);
        bus.m_ready[0] = 2'b10;
        cyc();
        bus.m_ready[0] = 2'b00;
        settle();
        chk("stag.next", 64'(bus.m_data[0]), 64'hB1);
        chk("stag.next_v", 64'(bus.m_valid[0]), 64'h3);
        chk("stag.occ1", 64'(bus.occupancy[0]), 64'd1);
        bus.m_ready[0] = 2'b11;
        cyc();

        // full and pointer wrap
        bus.m_ready = '0;
        k = 0;
        while (k < 4) begin
            bus.s_valid[0] = 1'b1;
            bus.s_data[0]  = DW'(32'h10 + k);
            cyc();
            k++;
        end
        bus.s_data[0] = DW'(32'h14);
        settle();
        chk("full.s_ready", 64'(bus.s_ready[0]), 64'd0);
        chk("full.occ", 64'(bus.occupancy[0]), 64'd4);
        obs0.delete();
        bus.m_ready[0] = 2'b11;
        for (int i = 0; i < 12; i++) begin
            if (k < 6) begin
                bus.s_valid[0] = 1'b1;
                bus.s_data[0]  = DW'(32'h10 + k);
            end else begin
                bus.s_valid[0] = 1'b0;
            end
            cyc();
            if (acc[0]) k++;
        end
        chk("wrap.count", 64'(obs0.size()), 64'd6);
        for (int i = 0; i < 6 && i < obs0.size(); i++)
            chk($sformatf("wrap.order%0d", i), 64'(obs0[i]), 64'(32'h10 + i));

        // consumer mask changes
        bus.m_ready = '0;
        bus.s_valid[0] = 1'b1;
        bus.s_data[0]  = 'hC0;
        cyc();
        bus.s_data[0]  = 'hC1;
        cyc();
        bus.s_valid[0] = 1'b0;
        bus.m_ready[0] = 2'b01;
        cyc();
        bus.m_ready[0] = 2'b00;
        en = 2'b01;
        settle();
        chk("mask.m_valid", 64'(bus.m_valid[0]), 64'h0);
        cyc();
        settle();
        chk("mask.occ1", 64'(bus.occupancy[0]), 64'd1);
        chk("mask.head", 64'(bus.m_data[0]), 64'hC1);
        en = 2'b00;
        bus.s_valid[0] = 1'b1;
        bus.s_data[0]  = 'hC2;
        cyc();
        bus.s_valid[0] = 1'b0;
        bus.m_ready[0] = 2'b11;
        cyc();
        cyc();
        cyc();
        settle();
        chk("mask.hold_occ", 64'(bus.occupancy[0]), 64'd2);
        chk("mask.none_v", 64'(bus.m_valid[0]), 64'h0);
        en = 2'b11;
        cyc();
        cyc();

        // flush with simultaneous push
        bus.m_ready = '0;
        bus.s_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.s_data[0] = DW'(32'hD0 + i);
            cyc();
        end
        bus.s_valid[0] = 1'b0;
        bus.m_ready[0] = 2'b01;
        cyc();
        bus.m_ready[0] = 2'b00;
        settle();
        chk("flush.occ3", 64'(bus.occupancy[0]), 64'd3);
        flush = 1'b1;
        bus.s_valid[0] = 1'b1;
        bus.s_data[0]  = 'hDD;
        settle();
        chk("flush.s_ready", 64'(bus.s_ready[0]), 64'd0);
        cyc();
        flush = 1'b0;
        bus.s_valid[0] = 1'b0;
        settle();
        chk("flush.occ0", 64'(bus.occupancy[0]), 64'd0);
        chk("flush.m_valid", 64'(bus.m_valid[0]), 64'h0);

        // asynchronous reset mid-cycle
        bus.s_valid[2] = 1'b1;
        bus.s_data[2]  = 'hE0;
        cyc();
        bus.s_valid[2] = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst.occ", 64'(bus.occupancy[2]), 64'd0);
        chk("arst.m_valid", 64'(bus.m_valid[2]), 64'h0);
        chk("arst.s_ready", 64'(bus.s_ready[2]), 64'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        settle();
        chk("arst.rel", 64'(bus.s_ready[2]), 64'd1);

        // stream independence: stream 1 stalled, stream 0 at full rate
        en = 2'b11;
        seq0 = 'h100;
        for (int s = 0; s < NS; s++) pops[s] = 0;
        for (int i = 0; i < 200; i++) begin
            if (acc[0]) seq0 = seq0 + 1;
            bus.s_valid[0] = 1'b1;
            bus.s_data[0]  = seq0;
            bus.m_ready[0] = 2'b11;
            drive_rand(1, 60, 0);
            drive_rand(2, 50, 50);
            drive_rand(3, 70, 30);
            if (i == 1) pops[0] = 0;
            cyc();
        end
        chk("indep.rate0", 64'(pops[0]), 64'd199);
        settle();
        chk("indep.occ1", 64'(bus.occupancy[1]), 64'(D));

        // fully random traffic with mask changes and occasional flush
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) en = NC'($urandom);
            flush = ($urandom_range(0, 49) == 0);
            for (int s = 0; s < NS; s++)
                drive_rand(s, $urandom_range(20, 90), $urandom_range(20, 90));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
